// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard path: dependency-detector forwarding codes
// and the helper that turns them into a load-use decision.
package hazard_ctrl_pkg;

    localparam int DEP_W = 6;

    localparam logic [DEP_W-1:0] DEP_NONE      = 6'd0;
    localparam logic [DEP_W-1:0] DEP_ALU_EX    = 6'd1;
    localparam logic [DEP_W-1:0] DEP_ALU_MEM   = 6'd2;
    localparam logic [DEP_W-1:0] DEP_MEMRD_EX  = 6'd3;
    localparam logic [DEP_W-1:0] DEP_MEMRD_MEM = 6'd4;
    localparam logic [DEP_W-1:0] DEP_WB        = 6'd5;

    // Only a load still in EX cannot be forwarded in time; every other code forwards.
    function automatic logic is_load_use(input logic [DEP_W-1:0] rs, input logic [DEP_W-1:0] rt);
        return (rs == DEP_MEMRD_EX) || (rt == DEP_MEMRD_EX);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the ID-stage dependency detector (master) and the hazard
// controller (slave): hazard indications in, pipeline register controls out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import hazard_ctrl_pkg::*;

    logic [DEP_W-1:0] dep_code_rs;
    logic [DEP_W-1:0] dep_code_rt;
    logic             redirect_ID;
    logic             halt_ID;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output dep_code_rs, dep_code_rt, redirect_ID, halt_ID,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, halted,
        input  stall_count, flush_count
    );

    modport slave (
        input  dep_code_rs, dep_code_rt, redirect_ID, halt_ID,
        output pc_write, ifid_write, ifid_flush, idex_bubble, halted,
        output stall_count, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: one-cycle load-use stall, redirect flush,
// HLT drain-then-freeze, plus saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);

    // state    | meaning
    // ST_RUN      | normal flow, load-use stalls allowed
    // ST_LD_STALL | cycle after a stall; load now in MEM, load-use ignored
    // ST_DRAIN    | HLT past ID, letting EX/MEM/WB empty
    // ST_HALTED   | pipeline frozen until reset
    typedef enum logic [1:0] {
        ST_RUN,
        ST_LD_STALL,
        ST_DRAIN,
        ST_HALTED
    } hz_state_e;

    hz_state_e  state_q, state_d;
    logic [1:0] drain_q, drain_d;

    logic load_use;
    logic stall_inc;
    logic flush_inc;
    logic pc_write, ifid_write, ifid_flush, idex_bubble;

    assign load_use = is_load_use(hz.dep_code_rs, hz.dep_code_rt);

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        unique case (state_q)
            ST_RUN, ST_LD_STALL: begin
                if (load_use && (state_q == ST_RUN)) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                    state_d     = ST_LD_STALL;
                end else if (hz.halt_ID) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    drain_d    = 2'(DRAIN_CYC);
                    state_d    = ST_DRAIN;
                end else begin
                    if (hz.redirect_ID) begin
                        ifid_flush = 1'b1;
                        flush_inc  = 1'b1;
                    end
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                drain_d     = drain_q - 2'd1;
                if (drain_q == 2'd1) begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        endcase

        // Reset overrides everything, including the combinational controls.
        if (reset) begin
            state_d     = ST_RUN;
            drain_d     = 2'd0;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b0;
            flush_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        drain_q <= drain_d;
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.halted      = (state_q == ST_HALTED) && !reset;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (stall_inc),
        .count (hz.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (flush_inc),
        .count (hz.flush_count)
    );

endmodule
